multdiv_pw_unit: RTL and testbench
==================================

Name: multdiv_pw_unit

Overview:
Iterative multiply/divide unit in the execute/PW slot of the 5-stage pipeline. Decodes mul/div from the D/X instruction, runs a multi-cycle shift-add multiply or restoring divide, and raises pw_stall to freeze F/D and D/X (consumed by the hazard/stall logic) until the result is ready. On completion it presents the result, the held instruction and any exception (rstatus code) to the X/M latch for writeback.

Parameters:
MUL_OVF_CODE, 4, value written to $rstatus ($30) on multiply overflow
DIV_ZERO_CODE, 5, value written to $rstatus on divide by zero
RSTATUS_REG, 30, register index reported as exception destination

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
dx_ir  in  32  D/X instruction; opcode [31:27], rd [26:22], ALU op [6:2]
operand_a  in  32  bypassed rs value (signed)
operand_b  in  32  bypassed rt value (signed)
pw_stall  out  1  freeze upstream pipeline
result_valid  out  1  one-cycle pulse, result/pw_ir valid
result  out  32  signed product (low 32) or quotient
pw_ir  out  32  instruction that produced result
pw_rd  out  5  destination: pw_ir rd, or RSTATUS_REG on exception
exc_valid  out  1  exception with result_valid
exc_code  out  32  MUL_OVF_CODE / DIV_ZERO_CODE, else 0

Behaviour:
- Clock is clock; reset is synchronous and active-high, sampled on rising edge of clock.
- Decode: is_mul = opcode 00000 & ALU op 00110; is_div = opcode 00000 & ALU op 00111. start = (is_mul|is_div) & state==IDLE.
- States: IDLE, MUL, DIV, DONE. IDLE->MUL/DIV on start; MUL/DIV->DONE after 32 iterations (count 0..31); DONE->IDLE unconditionally. start suppressed in DONE (D/X still holds the finished instruction that cycle).
- On start edge: latch dx_ir into pw_ir, |operand_a|, |operand_b|, result sign (a[31]^b[31]), clear 6-bit counter.
- MUL: radix-2 shift-add into 64-bit accumulator, one multiplier bit per cycle. Final: negate if sign set; overflow = high 32 bits not all equal to bit 31 of low word, or sign mismatch vs expected when nonzero.
- DIV: restoring, one quotient bit per cycle on 32-bit magnitudes; quotient truncates toward zero, negated if sign set. b==0: result 0, exc_valid=1, exc_code=DIV_ZERO_CODE, still spends the full iteration count. 0x80000000 / -1 -> 0x80000000, no exception.
- pw_stall = start | (state==MUL) | (state==DIV); combinational, so asserted in the same cycle the mul/div sits in D/X. Low in DONE.
- Latency: op in D/X at cycle N -> result_valid high in cycle N+33 (32 iteration cycles N+1..N+32, DONE at N+33). pw_stall high cycles N..N+32.
- result, pw_ir, pw_rd, exc_* registered; held stable from DONE until next start. result_valid and exc_valid high only in DONE.
- Exception: pw_rd = RSTATUS_REG, exc_code as above, result = 0. No exception: pw_rd = pw_ir[26:22], exc_code = 0.
- Reset (any state, incl. mid-operation): state IDLE, counter 0, pw_stall 0 (unless start decoded), result_valid 0, result 0, pw_ir 0, pw_rd 0, exc_valid 0, exc_code 0; in-flight op discarded.
- Back-to-back: second mul/div arriving in D/X during IDLE following DONE starts normally.

Optional Feature:
MULTDIV_EARLY_OUT_EN: when defined, MUL leaves for DONE as soon as the remaining multiplier bits are all zero (minimum 1 iteration); pw_stall drops accordingly. DIV unaffected. When undefined, MUL always takes 32 iterations.

Test Plan:
- mul 7 * -3 in D/X at cycle N -> pw_stall high N..N+32, result_valid at N+33, result 0xFFFFFFEB, pw_rd = rd, exc_valid 0.
- mul 0x00010000 * 0x00010000 -> exc_valid 1, exc_code 4, pw_rd 30, result 0.
- div -17 / 5 -> result 0xFFFFFFFD (-3), 33-cycle latency; div 9 / 0 -> exc_code 5, pw_rd 30.
- Non-mul/div instruction (add) in D/X -> pw_stall 0, state stays IDLE, no result_valid.
- reset asserted at iteration 10 of a div -> next cycle pw_stall 0, all outputs 0; following mul completes normally.
- With MULTDIV_EARLY_OUT_EN: mul 5 * 3 -> result_valid within 3 cycles of start, result 15; without macro same op takes 33.

Source files
------------

// File: rtl/multdiv_pw_unit.sv
// Iterative shift-add multiply / restoring divide in the PW slot; MULTDIV_EARLY_OUT_EN lets MUL stop on zero multiplier.
// Latency: op in D/X at cycle N -> result_valid at N+33 (earlier for MUL with early-out); pw_stall freezes F/D, D/X meanwhile.
module multdiv_pw_unit #(
  parameter logic [31:0] MUL_OVF_CODE  = 32'd4,
  parameter logic [31:0] DIV_ZERO_CODE = 32'd5,
  parameter logic [4:0]  RSTATUS_REG   = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        pw_stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [31:0] pw_ir,
  output logic [4:0]  pw_rd,
  output logic        exc_valid,
  output logic [31:0] exc_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL   = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;

  logic [1:0]  state;
  logic [5:0]  count;
  logic        sign;
  logic [31:0] op_b;
  logic [63:0] shift_q;
  logic [63:0] acc;
  logic [31:0] result_q;
  logic [31:0] pw_ir_q;
  logic [4:0]  pw_rd_q;
  logic [31:0] exc_code_q;
  logic        exc_q;

  logic        is_mul, is_div, start;
  logic [31:0] mag_a, mag_b;

  assign is_mul = (dx_ir[31:27] == OPC_RTYPE) && (dx_ir[6:2] == ALU_MUL);
  assign is_div = (dx_ir[31:27] == OPC_RTYPE) && (dx_ir[6:2] == ALU_DIV);
  assign start  = (is_mul || is_div) && (state == S_IDLE);

  assign pw_stall = start || (state == S_MUL) || (state == S_DIV);

  assign mag_a = operand_a[31] ? (~operand_a + 32'd1) : operand_a;
  assign mag_b = operand_b[31] ? (~operand_b + 32'd1) : operand_b;

  // Multiply: shift_q holds the left-shifting multiplicand, op_b the right-shifting multiplier.
  logic [63:0] acc_nxt;
  logic [63:0] prod_s;
  logic        mul_ovf;
  logic        mul_last;

  assign acc_nxt = acc + (op_b[0] ? shift_q : 64'd0);
  assign prod_s  = sign ? (~acc_nxt + 64'd1) : acc_nxt;
  assign mul_ovf = (prod_s[63:32] != {32{prod_s[31]}}) ||
                   ((acc_nxt != 64'd0) && (prod_s[31] != sign));

`ifdef MULTDIV_EARLY_OUT_EN
  assign mul_last = (count == 6'd31) || (op_b[31:1] == 31'd0);
`else
  assign mul_last = (count == 6'd31);
`endif

  // Divide: shift_q is {remainder, dividend/quotient}; op_b is the divisor magnitude.
  logic [32:0] rem_sh;
  logic        q_bit;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] quo_s;

  assign rem_sh  = {shift_q[63:32], shift_q[31]};
  assign q_bit   = (rem_sh >= {1'b0, op_b});
  assign rem_nxt = q_bit ? (rem_sh[31:0] - op_b) : rem_sh[31:0];
  assign quo_nxt = {shift_q[30:0], q_bit};
  assign quo_s   = sign ? (~quo_nxt + 32'd1) : quo_nxt;

  logic        fin_last;
  logic        fin_exc;
  logic [31:0] fin_res;
  logic [31:0] fin_code;

  always_comb begin
    fin_last = 1'b0;
    fin_exc  = 1'b0;
    fin_res  = 32'd0;
    fin_code = 32'd0;
    case (state)
      S_MUL: begin
        fin_last = mul_last;
        fin_exc  = mul_ovf;
        fin_res  = mul_ovf ? 32'd0 : prod_s[31:0];
        fin_code = mul_ovf ? MUL_OVF_CODE : 32'd0;
      end
      S_DIV: begin
        fin_last = (count == 6'd31);
        fin_exc  = (op_b == 32'd0);
        fin_res  = fin_exc ? 32'd0 : quo_s;
        fin_code = fin_exc ? DIV_ZERO_CODE : 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= 6'd0;
      sign       <= 1'b0;
      op_b       <= 32'd0;
      shift_q    <= 64'd0;
      acc        <= 64'd0;
      result_q   <= 32'd0;
      pw_ir_q    <= 32'd0;
      pw_rd_q    <= 5'd0;
      exc_code_q <= 32'd0;
      exc_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= is_mul ? S_MUL : S_DIV;
            count   <= 6'd0;
            sign    <= operand_a[31] ^ operand_b[31];
            pw_ir_q <= dx_ir;
            op_b    <= mag_b;
            shift_q <= {32'd0, mag_a};
            acc     <= 64'd0;
          end
        end
        S_MUL: begin
          acc     <= acc_nxt;
          shift_q <= {shift_q[62:0], 1'b0};
          op_b    <= {1'b0, op_b[31:1]};
          count   <= count + 6'd1;
        end
        S_DIV: begin
          shift_q <= {rem_nxt, quo_nxt};
          count   <= count + 6'd1;
        end
        default: state <= S_IDLE;
      endcase

      if (fin_last) begin
        state      <= S_DONE;
        result_q   <= fin_res;
        exc_q      <= fin_exc;
        exc_code_q <= fin_code;
        pw_rd_q    <= fin_exc ? RSTATUS_REG : pw_ir_q[26:22];
      end
    end
  end

  assign result_valid = (state == S_DONE);
  assign exc_valid    = (state == S_DONE) && exc_q;
  assign result       = result_q;
  assign pw_ir        = pw_ir_q;
  assign pw_rd        = pw_rd_q;
  assign exc_code     = exc_code_q;

endmodule

// File: tb/tb_multdiv_pw_unit.sv
// Directed bench for multdiv_pw_unit: latency, stall window, results, exceptions and reset behaviour.
module tb_multdiv_pw_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_ir;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        pw_stall;
  logic        result_valid;
  logic [31:0] result;
  logic [31:0] pw_ir;
  logic [4:0]  pw_rd;
  logic        exc_valid;
  logic [31:0] exc_code;

  int checks = 0;
  int errors = 0;

`ifdef MULTDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'd0;

  multdiv_pw_unit dut (
    .clock        (clock),
    .reset        (reset),
    .dx_ir        (dx_ir),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .pw_stall     (pw_stall),
    .result_valid (result_valid),
    .result       (result),
    .pw_ir        (pw_ir),
    .pw_rd        (pw_rd),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] alu);
    return {opc, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one op into D/X at the next cycle and follows it to DONE.
  task automatic do_op(input string tag, input logic [31:0] ir, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                       input logic [4:0] exp_rd, input logic exp_exc, input logic [31:0] exp_code);
    int lat;
    int stall_cnt;
    @(posedge clock); #1;
    dx_ir = ir; operand_a = a; operand_b = b;
    #1;
    stall_cnt = (pw_stall === 1'b1) ? 1 : 0;
    lat = 0;
    while (result_valid !== 1'b1 && lat < 200) begin
      @(posedge clock); #2;
      lat++;
      if (pw_stall === 1'b1) stall_cnt++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".stall_cycles"}, stall_cnt, exp_lat);
    chk({tag, ".stall_in_done"}, {31'd0, pw_stall}, 32'd0);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".pw_ir"}, pw_ir, ir);
    chk({tag, ".pw_rd"}, {27'd0, pw_rd}, {27'd0, exp_rd});
    chk({tag, ".exc_valid"}, {31'd0, exc_valid}, {31'd0, exp_exc});
    chk({tag, ".exc_code"}, exc_code, exp_code);
  endtask

  initial begin
    int busy;
    logic [31:0] ir;

    reset = 1'b1; dx_ir = NOP; operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(posedge clock);
    #2;
    chk("rst.pw_stall", {31'd0, pw_stall}, 32'd0);
    chk("rst.result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.pw_ir", pw_ir, 32'd0);
    chk("rst.pw_rd", {27'd0, pw_rd}, 32'd0);
    chk("rst.exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rst.exc_code", exc_code, 32'd0);
    reset = 1'b0;

    // add, and an I-type opcode that happens to carry the MUL ALU field: neither may start
    @(posedge clock); #1;
    dx_ir = mk(5'b00000, 5'd3, 5'b00000); operand_a = 32'd4; operand_b = 32'd5;
    #1;
    chk("add.pw_stall", {31'd0, pw_stall}, 32'd0);
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #2;
      if (pw_stall !== 1'b0 || result_valid !== 1'b0) busy++;
      if (i == 20) dx_ir = mk(5'b00101, 5'd3, 5'b00110);
    end
    chk("nonmuldiv.activity", busy, 0);

    do_op("mul7x-3", mk(5'd0, 5'd5, 5'b00110), 32'd7, 32'hFFFF_FFFD,
          EARLY ? 3 : 33, 32'hFFFF_FFEB, 5'd5, 1'b0, 32'd0);
    // back-to-back: the next op enters in the IDLE cycle right after DONE
    do_op("mul_ovf", mk(5'd0, 5'd6, 5'b00110), 32'h0001_0000, 32'h0001_0000,
          EARLY ? 18 : 33, 32'd0, 5'd30, 1'b1, 32'd4);
    do_op("mul_ovf31", mk(5'd0, 5'd13, 5'b00110), 32'h4000_0000, 32'd2,
          EARLY ? 3 : 33, 32'd0, 5'd30, 1'b1, 32'd4);
    do_op("mul_minint", mk(5'd0, 5'd14, 5'b00110), 32'h8000_0000, 32'd1,
          EARLY ? 2 : 33, 32'h8000_0000, 5'd14, 1'b0, 32'd0);
    do_op("mul-4x-5", mk(5'd0, 5'd15, 5'b00110), 32'hFFFF_FFFC, 32'hFFFF_FFFB,
          EARLY ? 4 : 33, 32'd20, 5'd15, 1'b0, 32'd0);
    do_op("mul5x3", mk(5'd0, 5'd10, 5'b00110), 32'd5, 32'd3,
          EARLY ? 3 : 33, 32'd15, 5'd10, 1'b0, 32'd0);

    @(posedge clock); #1;
    dx_ir = NOP;
    #1;
    chk("hold.result_valid", {31'd0, result_valid}, 32'd0);
    chk("hold.result", result, 32'd15);
    chk("hold.pw_rd", {27'd0, pw_rd}, 32'd10);

    do_op("div-17/5", mk(5'd0, 5'd7, 5'b00111), 32'hFFFF_FFEF, 32'd5,
          33, 32'hFFFF_FFFD, 5'd7, 1'b0, 32'd0);
    do_op("div_minint", mk(5'd0, 5'd9, 5'b00111), 32'h8000_0000, 32'hFFFF_FFFF,
          33, 32'h8000_0000, 5'd9, 1'b0, 32'd0);
    do_op("div9/0", mk(5'd0, 5'd8, 5'b00111), 32'd9, 32'd0,
          33, 32'd0, 5'd30, 1'b1, 32'd5);

    // reset while a divide is at its tenth iteration
    ir = mk(5'd0, 5'd12, 5'b00111);
    @(posedge clock); #1;
    dx_ir = ir; operand_a = 32'd100; operand_b = 32'd7;
    #1;
    chk("rstmid.start_stall", {31'd0, pw_stall}, 32'd1);
    repeat (10) @(posedge clock);
    @(posedge clock); #1;
    chk("rstmid.busy_before", {31'd0, pw_stall}, 32'd1);
    reset = 1'b1; dx_ir = NOP;
    @(posedge clock); #2;
    chk("rstmid.pw_stall", {31'd0, pw_stall}, 32'd0);
    chk("rstmid.result_valid", {31'd0, result_valid}, 32'd0);
    chk("rstmid.result", result, 32'd0);
    chk("rstmid.pw_ir", pw_ir, 32'd0);
    chk("rstmid.pw_rd", {27'd0, pw_rd}, 32'd0);
    chk("rstmid.exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rstmid.exc_code", exc_code, 32'd0);
    reset = 1'b0;

    do_op("mul6x7", mk(5'd0, 5'd11, 5'b00110), 32'd6, 32'd7,
          EARLY ? 4 : 33, 32'd42, 5'd11, 1'b0, 32'd0);

    @(posedge clock); #1;
    dx_ir = NOP;
    #1;
    chk("end.pw_stall", {31'd0, pw_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
